// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared state type and fixed-point helpers for the Mandelbrot engine
package mandel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_INIT,
    S_PIX_INIT,
    S_ITER,
    S_EMIT,
    S_DONE
  } state_t;

  // 4.0 expressed at the scale of a full product (2*frac_w fractional bits)
  function automatic logic [63:0] esc_threshold(input int frac_w);
    return 64'd4 << (2 * frac_w);
  endfunction

  function automatic logic signed [63:0] fx_trunc(input logic signed [63:0] p, input int frac_w);
    return p >>> frac_w;
  endfunction

endpackage

// File: rtl/mandel_iter_step.sv
// rtl/mandel_iter_step.sv - one combinational z <- z^2 + c step with escape test
module mandel_iter_step
  import mandel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] cx,
  input  logic signed [DATA_W-1:0] cy,
  output logic signed [DATA_W-1:0] a_next,
  output logic signed [DATA_W-1:0] b_next,
  output logic                     escape
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] ESC_LIMIT = SW'(esc_threshold(FRAC_W));

  logic signed [PW-1:0] w_aa;
  logic signed [PW-1:0] w_bb;
  logic signed [PW-1:0] w_ab;
  logic signed [SW-1:0] w_aa_x;
  logic signed [SW-1:0] w_bb_x;
  logic signed [SW-1:0] w_mag;
  logic signed [SW-1:0] w_diff;
  logic signed [SW-1:0] w_ab2;

  assign w_aa = PW'(a) * PW'(a);
  assign w_bb = PW'(b) * PW'(b);
  assign w_ab = PW'(a) * PW'(b);

  // One extra bit keeps |z|^2 and 2ab exact before truncation
  assign w_aa_x = SW'(w_aa);
  assign w_bb_x = SW'(w_bb);
  assign w_mag  = w_aa_x + w_bb_x;
  assign w_diff = w_aa_x - w_bb_x;
  assign w_ab2  = SW'(w_ab) <<< 1;

  assign escape = w_mag > ESC_LIMIT;
  assign a_next = DATA_W'(fx_trunc(64'(w_diff), FRAC_W)) + cx;
  assign b_next = DATA_W'(fx_trunc(64'(w_ab2), FRAC_W)) + cy;

endmodule

// File: rtl/mandel_scan_engine.sv
// rtl/mandel_scan_engine.sv - frame scanner running escape-time iteration per pixel
// Optional MANDEL_ABORT_EN adds an abort input that returns any active frame to idle.
module mandel_scan_engine
  import mandel_pkg::*;
#(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 12,
  parameter int MAX_ITER = 255,
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1,
  localparam int IW = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MANDEL_ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              plot_valid,
  input  logic              plot_ready,
  output logic [XW-1:0]     plot_x,
  output logic [YW-1:0]     plot_y,
  output logic [IW-1:0]     plot_iter,
  output logic              plot_in_set
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [IW-1:0] N_LAST = IW'(MAX_ITER);

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_x0;
  logic signed [DATA_W-1:0]  r_step;
  logic signed [DATA_W-1:0]  r_cx;
  logic signed [DATA_W-1:0]  r_cy;
  logic signed [DATA_W-1:0]  r_a;
  logic signed [DATA_W-1:0]  r_b;
  logic [IW-1:0]             r_n;
  logic [XW-1:0]             r_i;
  logic [YW-1:0]             r_j;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_valid;
  logic [IW-1:0]             r_iter;
  logic                      r_in_set;

  logic signed [DATA_W-1:0]  w_a_next;
  logic signed [DATA_W-1:0]  w_b_next;
  logic                      w_escape;

  mandel_iter_step #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_step (
    .a      (r_a),
    .b      (r_b),
    .cx     (r_cx),
    .cy     (r_cy),
    .a_next (w_a_next),
    .b_next (w_b_next),
    .escape (w_escape)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_step   <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_iter   <= '0;
      r_in_set <= 1'b0;
    end
`ifdef MANDEL_ABORT_EN
    else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end
`endif
    else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0    <= x0;
            r_step  <= step;
            r_cy    <= y0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ROW_INIT;
          end
        end
        S_ROW_INIT: begin
          r_i     <= '0;
          r_cx    <= r_x0;
          r_state <= S_PIX_INIT;
        end
        S_PIX_INIT: begin
          r_a     <= '0;
          r_b     <= '0;
          r_n     <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          // Escape is checked on the current z, so hitting the limit while escaping reports an escape
          if (w_escape || (r_n == N_LAST)) begin
            r_iter   <= r_n;
            r_in_set <= !w_escape;
            r_valid  <= 1'b1;
            r_state  <= S_EMIT;
          end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            r_n <= r_n + 1'b1;
          end
        end
        S_EMIT: begin
          if (plot_ready) begin
            r_valid <= 1'b0;
            if (r_i != X_LAST) begin
              r_i     <= r_i + 1'b1;
              r_cx    <= r_cx + r_step;
              r_state <= S_PIX_INIT;
            end else if (r_j != Y_LAST) begin
              r_j     <= r_j + 1'b1;
              r_cy    <= r_cy - r_step;
              r_state <= S_ROW_INIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign plot_valid  = r_valid;
  assign plot_x      = r_i;
  assign plot_y      = r_j;
  assign plot_iter   = r_iter;
  assign plot_in_set = r_in_set;

endmodule

// File: doc/mandel_scan_engine.md
# mandel_scan_engine

Parametrised Mandelbrot frame engine: on `start` it scans an H_RES × V_RES pixel grid and runs the escape-time iteration z ← z² + c in signed fixed point, one iteration per clock. It emits one result per pixel (x, y, iteration count, in-set flag) over a valid/ready plot interface. It sits between the host/control logic and the frame-buffer/VGA writer, and adds configurable resolution, precision and iteration depth, plot-side backpressure and a restartable frame.

## Interface
Parameters:
- H_RES, 160, pixels per row.
- V_RES, 120, rows per frame.
- DATA_W, 16, total fixed-point width: signed two's complement, Q(DATA_W−FRAC_W).FRAC_W.
- FRAC_W, 12, fractional bits.
- MAX_ITER, 255, iteration limit (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- x0  in  DATA_W  real part of c at pixel (0,0); latched on start.
- y0  in  DATA_W  imaginary part of c at pixel (0,0); latched on start.
- step  in  DATA_W  c increment per pixel/row; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pixel transfers.
- plot_valid  out  1  result present.
- plot_ready  in  1  consumer accepts.
- plot_x  out  $clog2(H_RES)  column.
- plot_y  out  $clog2(V_RES)  row.
- plot_iter  out  $clog2(MAX_ITER+1)  escape iteration count.
- plot_in_set  out  1  high when the limit was reached without escape.

## Operation
- States: IDLE, ROW_INIT, PIX_INIT, ITER, EMIT, DONE.
- IDLE → ROW_INIT on start. Latch x0/y0/step; j←0; cy←y0.
- ROW_INIT → PIX_INIT. i←0; cx←x0_latched.
- PIX_INIT → ITER. a←0; b←0; n←0.
- ITER, each cycle:
  - escape = a²+b² > 4.0, evaluated on the full 2·DATA_W-bit products, before truncation, with a sum 1 bit wider.
  - If escape or n==MAX_ITER: go to EMIT and capture iter=n, in_set=(¬escape).
  - Otherwise: a←trunc(a²−b²)+cx; b←trunc(2ab)+cy; n←n+1.
  - trunc means arithmetic shift right FRAC_W, keep the low DATA_W bits. Overflow wraps; no saturation.
- EMIT: plot_valid=1 with stable x/y/iter/in_set until plot_valid&plot_ready. On transfer:
  - If i<H_RES−1: i←i+1, cx←cx+step, go to PIX_INIT.
  - Else if j<V_RES−1: j←j+1, cy←cy−step (rows advance downward), go to ROW_INIT.
  - Else go to DONE.
- DONE → IDLE, asserting done for that single cycle. A new start is accepted in IDLE on the following cycle.
- start in any non-IDLE state is ignored.

## Timing
- Reset, asynchronous: state=IDLE. busy, done, plot_valid, plot_x, plot_y, plot_iter, plot_in_set all 0; internal registers 0.
- Per-pixel latency, from entering PIX_INIT to plot_valid: 1 + (n+1) cycles, where n is the captured iter. Worst case is MAX_ITER+2.
- First pixel: plot_valid no earlier than 3+(n+1) cycles after the start cycle (IDLE, ROW_INIT, PIX_INIT).
- Backpressure: with plot_ready low, the engine holds EMIT indefinitely with outputs stable. No iteration overlaps EMIT.
- With plot_ready tied high, EMIT lasts exactly one cycle.
- Boundary n==MAX_ITER with escape true in the same cycle: in_set=0, iter=MAX_ITER.
- |z|²==4.0 exactly is not an escape.
- Reset mid-frame aborts immediately. There is no done pulse, and the next frame requires a new start.

## Configuration
- Macro MANDEL_ABORT_EN.
- Defined: adds input port `abort` (1 bit). abort high in any non-IDLE state forces IDLE on the next edge.
  - plot_valid drops even mid-handshake. This is the only permitted valid retraction.
  - No done pulse.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Undefined: no `abort` port. A frame always runs to completion.

## Structure
- Package mandel_pkg:
  - state enum typedef.
  - escape threshold constant 4.0 << (2·FRAC_W), expressed as a function of FRAC_W.
  - helper function for fixed-point truncation.
- Sub-module mandel_iter_step: purely combinational. Inputs a, b, cx, cy; outputs a_next, b_next, escape. Instantiated once by the engine, which holds the FSM, counters and the cx/cy accumulators.

## Test plan
All scenarios use H_RES=4, V_RES=2, DATA_W=16, FRAC_W=12, MAX_ITER=15.
- Scan order: x0=0xE000 (−2.0), y0=0, step=0x1000, ready=1.
  - Required: eight transfers in order (0,0)…(3,0),(0,1)…(3,1).
  - Row 0 iters: 15/in, 15/in, 15/in, 3/out. Then one done pulse, then busy=0.
- Escape boundary: c=2.0 → iter=2, in_set=0. c=−2.0 (|z|²=4 exactly) → iter=15, in_set=1.
- Backpressure: ready=0 for 10 cycles on pixel (1,0). Required: valid and data stable for all 10 cycles, exactly one transfer, no skipped or duplicated pixel.
- Start ignored and restart: pulse start while busy → no effect. After done, start again with new x0 → second frame reflects the new latched values.
- Reset mid-ITER: drive rst=0 asynchronously → all outputs 0 immediately, no done. A subsequent start runs a full 8-pixel frame.
- MANDEL_ABORT_EN: abort while EMIT is stalled → IDLE next cycle, plot_valid=0, no done. abort+start together in IDLE → frame starts.
